// File: rtl/contador_3bits_sd_if.sv
// Step-request / counter-display bundle between the divider-side controller
// and the 3-bit display counter.
interface contador_3bits_sd_if;
  logic       tick_in;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       wrap;
  logic [6:0] seg;

  modport master (
    output tick_in, enable, up_down, load, load_val,
    input  count, wrap, seg
  );

  modport slave (
    input  tick_in, enable, up_down, load, load_val,
    output count, wrap, seg
  );
endinterface

// File: rtl/contador_3bits_sd.sv
// 3-bit up/down wrap counter stepped by rising edges of the divider output,
// fully on the system clock, with synchronous load and 7-segment decode.
module contador_3bits_sd #(
  parameter int unsigned MAX            = 7,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  contador_3bits_sd_if.slave  bus
);

  localparam logic [2:0] MAX_V = 3'(MAX);

  logic       s1, s2, s3;
  logic [2:0] primed;
  logic       step;
  logic [2:0] count_q;
  logic       wrap_q;
  logic [6:0] seg_ah;

  // primed[2] marks s3 as holding a real sample, so a tick_in already high
  // at reset release is not mistaken for a rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      primed <= '0;
    end else begin
      s1     <= bus.tick_in;
      s2     <= s1;
      s3     <= s2;
      primed <= {primed[1:0], 1'b1};
    end
  end

  assign step = s2 & ~s3 & primed[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.load) begin
        count_q <= (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
      end else if (step && bus.enable) begin
        if (bus.up_down) begin
          if (count_q >= MAX_V) begin
            count_q <= '0;
            wrap_q  <= (count_q == MAX_V);
          end else begin
            count_q <= count_q + 3'd1;
          end
        end else begin
          if (count_q == 3'd0) begin
            count_q <= MAX_V;
            wrap_q  <= 1'b1;
          end else if (count_q > MAX_V) begin
            count_q <= MAX_V;
          end else begin
            count_q <= count_q - 3'd1;
          end
        end
      end
    end
  end

  always_comb begin
    seg_ah = '0;
    case (count_q)
      3'd0: seg_ah = 7'h3F;
      3'd1: seg_ah = 7'h06;
      3'd2: seg_ah = 7'h5B;
      3'd3: seg_ah = 7'h4F;
      3'd4: seg_ah = 7'h66;
      3'd5: seg_ah = 7'h6D;
      3'd6: seg_ah = 7'h7D;
      3'd7: seg_ah = 7'h07;
      default: seg_ah = '0;
    endcase
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.seg   = seg_ah ^ {7{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_contador_3bits_sd.sv
// Directed bench: MAX=7 active-low DUT (a) and MAX=5 active-high DUT (b)
// driven by identical stimulus, each checked against hand-computed values.
module tb_contador_3bits_sd;

  logic       clock;
  logic       reset;
  logic       tick, enable, up_down, load;
  logic [2:0] load_val;

  int checks   = 0;
  int failures = 0;
  logic wa1, wb1, wa2, wb2;

  logic [6:0] seg_al [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  logic [6:0] seg_ah [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

  contador_3bits_sd_if ia ();
  contador_3bits_sd_if ib ();

  assign ia.tick_in = tick;     assign ib.tick_in = tick;
  assign ia.enable = enable;    assign ib.enable = enable;
  assign ia.up_down = up_down;  assign ib.up_down = up_down;
  assign ia.load = load;        assign ib.load = load;
  assign ia.load_val = load_val; assign ib.load_val = load_val;

  contador_3bits_sd #(.MAX(7), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clock (clock), .reset (reset), .bus (ia)
  );
  contador_3bits_sd #(.MAX(5), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clock (clock), .reset (reset), .bus (ib)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // count and segment pattern of both DUTs
  task automatic check_both(input string tag, input int ea, input int eb);
    check({tag, "_cnt_a"}, int'(ia.count), ea);
    check({tag, "_cnt_b"}, int'(ib.count), eb);
    check({tag, "_seg_a"}, int'(ia.seg), int'(seg_al[ea]));
    check({tag, "_seg_b"}, int'(ib.seg), int'(seg_ah[eb]));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One tick_in period; wrap sampled on the update cycle and the one after.
  task automatic pulse();
    tick = 1'b1;
    cyc(3);
    wa1 = ia.wrap; wb1 = ib.wrap;
    cyc(1);
    wa2 = ia.wrap; wb2 = ib.wrap;
    tick = 1'b0;
    cyc(4);
  endtask

  task automatic do_load(input logic [2:0] v);
    load = 1'b1; load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    tick = 1'b0; enable = 1'b1; up_down = 1'b1; load = 1'b0; load_val = '0;
    reset = 1'b0;
    cyc(3);
    check_both("reset", 0, 0);
    check("reset_wrap_a", int'(ia.wrap), 0);
    check("reset_wrap_b", int'(ib.wrap), 0);
    reset = 1'b1;
    cyc(3);

    // Up count: a wraps 7->0 on tick 8, b wraps 5->0 on tick 6
    for (int i = 1; i <= 9; i++) begin
      pulse();
      check_both($sformatf("up%0d", i), i % 8, i % 6);
      check($sformatf("up%0d_wrap_a", i), int'(wa1), (i == 8) ? 1 : 0);
      check($sformatf("up%0d_wrap_b", i), int'(wb1), (i == 6) ? 1 : 0);
      check($sformatf("up%0d_wrap2_a", i), int'(wa2), 0);
      check($sformatf("up%0d_wrap2_b", i), int'(wb2), 0);
    end
    check("seg_one_a", int'(ia.seg), 'h79);

    // Latency: a=1, b=3; update lands exactly two edges after first sample
    tick = 1'b1;
    cyc(1); check_both("lat_n", 1, 3);
    cyc(1); check_both("lat_n1", 1, 3);
    cyc(1); check_both("lat_n2", 2, 4);
    cyc(3);
    tick = 1'b0;
    cyc(5); check_both("lat_fall", 2, 4);

    // Down wrap
    up_down = 1'b0;
    do_load(3'd0);
    check_both("ld0", 0, 0);
    pulse();
    check_both("dn1", 7, 5);
    check("dn1_wrap_a", int'(wa1), 1);
    check("dn1_wrap_b", int'(wb1), 1);
    check("dn1_wrap2_b", int'(wb2), 0);
    pulse();
    check_both("dn2", 6, 4);
    check("dn2_wrap_b", int'(wb1), 0);

    // Load beats a coincident step
    up_down = 1'b1;
    do_load(3'd3);
    tick = 1'b1;
    cyc(2);
    load = 1'b1; load_val = 3'd6;
    cyc(1);
    load = 1'b0;
    check_both("ldpri", 6, 5);
    check("ldpri_wrap_a", int'(ia.wrap), 0);
    cyc(3);
    check_both("ldpri_hold", 6, 5);
    tick = 1'b0;
    cyc(4);
    do_load(3'd7);
    check_both("ld7", 7, 5);

    // Held load suppresses steps
    load = 1'b1; load_val = 3'd2;
    pulse();
    load = 1'b0;
    check_both("ldhold", 2, 2);

    // Enable gating, no replay
    enable = 1'b0;
    for (int i = 0; i < 3; i++) pulse();
    check_both("en_off", 2, 2);
    enable = 1'b1;
    cyc(4);
    check_both("en_on_idle", 2, 2);
    pulse();
    check_both("en_on", 3, 3);

    // Async reset in the middle of a step
    do_load(3'd5);
    tick = 1'b1;
    cyc(1);
    #2 reset = 1'b0;
    #1;
    check_both("arst", 0, 0);
    cyc(2);
    reset = 1'b1;
    cyc(6);
    check_both("stale_high", 0, 0);
    tick = 1'b0;
    cyc(4);
    pulse();
    check_both("after_stale", 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
